axi_burst_seq: RTL and testbench
================================

AXI_BURST_SEQ -- requirements
Module: axi_burst_seq

Interface
REQ-001 SHALL have parameter AW, default 32, AXI address width (AW >= 12 not required).
REQ-002 SHALL have parameter DW, default 32, AXI data width; DSZ = $clog2(DW)-3 is the maximum legal size code.
REQ-003 SHALL have port S_AXI_ACLK  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port S_AXI_ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_req_valid  input  1  burst request valid.
REQ-006 SHALL have port o_req_ready  output  1  request accepted when valid and ready are both high.
REQ-007 SHALL have port i_req_addr  input  AW  start address (may be unaligned).
REQ-008 SHALL have port i_req_len  input  8  AXI LEN (beats minus one).
REQ-009 SHALL have port i_req_size  input  3  AXI SIZE (bytes = 1<<size).
REQ-010 SHALL have port i_req_burst  input  2  AXI BURST: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-011 SHALL have port o_beat_valid  output  1  beat address valid.
REQ-012 SHALL have port i_beat_ready  input  1  beat consumed when valid and ready are both high.
REQ-013 SHALL have port o_beat_addr  output  AW  address of current beat.
REQ-014 SHALL have port o_beat_idx  output  8  beat index, 0..len.
REQ-015 SHALL have port o_beat_last  output  1  high when o_beat_idx equals captured len.
REQ-016 SHALL have port o_busy  output  1  high whenever a burst is in progress.

Function
REQ-017 SHALL implement two states: IDLE (o_req_ready=1, o_beat_valid=0) and BURST (o_req_ready=0, o_beat_valid=1).
REQ-018 SHALL, on request handshake in IDLE, capture addr/len/size/burst, set o_beat_addr=i_req_addr, o_beat_idx=0, enter BURST; first beat valid the next cycle (1-cycle latency).
REQ-019 SHALL clamp captured size to DSZ when i_req_size > DSZ.
REQ-020 SHALL hold o_beat_addr, o_beat_idx, o_beat_last stable while o_beat_valid && !i_beat_ready.
REQ-021 SHALL, on each beat handshake with o_beat_last=0, increment o_beat_idx by 1 and load the next address the same edge.
REQ-022 SHALL compute INCR next address as (current address aligned down to 1<<size) + (1<<size).
REQ-023 SHALL hold the address constant for FIXED bursts.
REQ-024 SHALL compute WRAP next address as INCR result wrapped within the block aligned to (len+1)<<size; only len 1, 3, 7, 15 are WRAP-legal.
REQ-025 SHALL treat burst 2'b11 and WRAP with illegal len as INCR.
REQ-026 SHALL confine increments to address bits [min(AW,12)-1:0]; upper bits hold, so a burst never crosses a 4 kB page (wraps within it).
REQ-027 SHALL, on the handshake of the last beat, return to IDLE; o_req_ready rises the following cycle (no same-cycle back-to-back acceptance).
REQ-028 SHALL ignore i_req_valid while in BURST; o_busy equals (state == BURST).
REQ-029 SHALL support len=0: a single beat with o_beat_last=1 on its first valid cycle.

Reset
REQ-030 SHALL, on S_AXI_ARESETN low, immediately enter IDLE: o_req_ready=1, o_beat_valid=0, o_busy=0, o_beat_addr=0, o_beat_idx=0, o_beat_last=0.
REQ-031 SHALL, on reset mid-burst, abandon the burst with no further beats after release.
REQ-032 SHALL accept a new request on the first clock edge after reset release.

Configuration
REQ-033 SHALL compile WRAP support only when macro AXI_BURST_SEQ_WRAP_EN is defined; without it, all WRAP requests are sequenced as INCR and no wrap-mask logic exists.

Verification
REQ-034 SHALL pass: INCR, addr 0x1002, len 3, size 2 -> beats 0x1002, 0x1004, 0x1008, 0x100C; last on idx 3.
REQ-035 SHALL pass: INCR, addr 0x1FF8, len 3, size 2 -> 0x1FF8, 0x1FFC, 0x1000, 0x1004 (page confinement).
REQ-036 SHALL pass: WRAP, addr 0x1008, len 3, size 2, macro defined -> 0x1008, 0x100C, 0x1000, 0x1004; macro undefined -> 0x1008, 0x100C, 0x1010, 0x1014.
REQ-037 SHALL pass: FIXED, addr 0x40, len 2, with i_beat_ready low 3 cycles per beat -> 0x40 three times, outputs stable while stalled, o_req_ready high one cycle after last handshake.
REQ-038 SHALL pass: DW=32, size 3, INCR, addr 0x0, len 1 -> size clamped, beats 0x0, 0x4.
REQ-039 SHALL pass: reset asserted after beat 1 of an 8-beat INCR burst -> o_beat_valid low immediately, o_req_ready high, no stale beats after release.

Source files
------------

// File: rtl/axi_burst_seq.sv
// AXI burst address sequencer: accepts one burst request, then emits one beat address per handshake.
// Optional WRAP support is compiled in with AXI_BURST_SEQ_WRAP_EN; otherwise WRAP bursts sequence as INCR.
module axi_burst_seq #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          S_AXI_ACLK,
  input  logic          S_AXI_ARESETN,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [AW-1:0] i_req_addr,
  input  logic [7:0]    i_req_len,
  input  logic [2:0]    i_req_size,
  input  logic [1:0]    i_req_burst,
  output logic          o_beat_valid,
  input  logic          i_beat_ready,
  output logic [AW-1:0] o_beat_addr,
  output logic [7:0]    o_beat_idx,
  output logic          o_beat_last,
  output logic          o_busy
);

  localparam int DSZ = $clog2(DW) - 3;
  localparam int PW  = (AW < 12) ? AW : 12;
  // Only the in-page address bits may change, so bursts stay inside one 4 kB page.
  localparam logic [AW-1:0] PMASK = (PW == AW) ? {AW{1'b1}} : ((AW'(1) << PW) - AW'(1));

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_idx;
  logic [7:0]    r_len;
  logic [2:0]    r_size;
  logic          r_fixed;
  logic          w_req_hs;
  logic          w_beat_hs;
  logic          w_last;
  logic [2:0]    w_size_cap;
  logic [AW-1:0] w_bytes;
  logic [AW-1:0] w_incr;
  logic [AW-1:0] w_cand;
  logic [AW-1:0] w_next;
`ifdef AXI_BURST_SEQ_WRAP_EN
  logic          r_wrap;
  logic          w_wrap_ok;
  logic [AW-1:0] w_wmask;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    o_req_ready  = 1'b0;
    o_beat_valid = 1'b0;
    o_busy       = 1'b0;
    o_beat_last  = 1'b0;
    w_req_hs     = 1'b0;
    w_beat_hs    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        w_req_hs    = i_req_valid;
        if (i_req_valid) w_state_nxt = S_BURST;
      end
      S_BURST: begin
        o_beat_valid = 1'b1;
        o_busy       = 1'b1;
        o_beat_last  = w_last;
        w_beat_hs    = i_beat_ready;
        if (i_beat_ready && w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  assign w_last     = (r_idx == r_len);
  assign w_size_cap = (i_req_size > 3'(DSZ)) ? 3'(DSZ) : i_req_size;
  assign w_bytes    = AW'(1) << r_size;
  assign w_incr     = (r_addr & ~(w_bytes - AW'(1))) + w_bytes;

`ifdef AXI_BURST_SEQ_WRAP_EN
  assign w_wrap_ok = (i_req_burst == 2'b10) &&
                     ((i_req_len == 8'd1) || (i_req_len == 8'd3) ||
                      (i_req_len == 8'd7) || (i_req_len == 8'd15));
  // Wrap block is (len+1) beats of 1<<size bytes, naturally aligned.
  assign w_wmask   = ((AW'(r_len) + AW'(1)) << r_size) - AW'(1);
  assign w_cand    = r_fixed ? r_addr :
                     r_wrap  ? ((r_addr & ~w_wmask) | (w_incr & w_wmask)) : w_incr;
`else
  assign w_cand    = r_fixed ? r_addr : w_incr;
`endif

  assign w_next = (r_addr & ~PMASK) | (w_cand & PMASK);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_addr  <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_fixed <= 1'b0;
`ifdef AXI_BURST_SEQ_WRAP_EN
      r_wrap  <= 1'b0;
`endif
    end else if (w_req_hs) begin
      r_addr  <= i_req_addr;
      r_idx   <= '0;
      r_len   <= i_req_len;
      r_size  <= w_size_cap;
      r_fixed <= (i_req_burst == 2'b00);
`ifdef AXI_BURST_SEQ_WRAP_EN
      r_wrap  <= w_wrap_ok;
`endif
    end else if (w_beat_hs && !w_last) begin
      r_addr  <= w_next;
      r_idx   <= r_idx + 8'd1;
    end
  end

  assign o_beat_addr = r_addr;
  assign o_beat_idx  = r_idx;

endmodule

// File: tb/tb_axi_burst_seq.sv
// Self-checking bench for axi_burst_seq: directed vectors plus randomized bursts against a closed-form address model.
module tb_axi_burst_seq;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int DSZ = $clog2(DW) - 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic [AW-1:0] i_req_addr = '0;
  logic [7:0]    i_req_len = '0;
  logic [2:0]    i_req_size = '0;
  logic [1:0]    i_req_burst = '0;
  logic          o_beat_valid;
  logic          i_beat_ready = 1'b0;
  logic [AW-1:0] o_beat_addr;
  logic [7:0]    o_beat_idx;
  logic          o_beat_last;
  logic          o_busy;

  int            tests = 0;
  int            fails = 0;
  logic [31:0]   obs [0:255];

  axi_burst_seq #(.AW(AW), .DW(DW)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_addr    (i_req_addr),
    .i_req_len     (i_req_len),
    .i_req_size    (i_req_size),
    .i_req_burst   (i_req_burst),
    .o_beat_valid  (o_beat_valid),
    .i_beat_ready  (i_beat_ready),
    .o_beat_addr   (o_beat_addr),
    .o_beat_idx    (o_beat_idx),
    .o_beat_last   (o_beat_last),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Beat k address from the AXI rules, computed directly rather than stepped.
  function automatic logic [31:0] model_addr(input logic [31:0] a, input int len, input int sz,
                                             input logic [1:0] bt, input int k);
    longint unsigned ua, bytes, blk, base, al, page, off;
    int  s;
    bit  wrap;
    ua    = a;
    s     = (sz > DSZ) ? DSZ : sz;
    bytes = 64'd1 << s;
    wrap  = 1'b0;
    if (k == 0 || bt == 2'b00) return a;
`ifdef AXI_BURST_SEQ_WRAP_EN
    wrap = (bt == 2'b10) && (len == 1 || len == 3 || len == 7 || len == 15);
`endif
    if (wrap) begin
      blk  = longint'(len + 1) * bytes;
      base = ua - (ua % blk);
      al   = ua - (ua % bytes);
      return 32'(base + ((al - base) + longint'(k) * bytes) % blk);
    end
    page = ua - (ua % 4096);
    off  = ua % 4096;
    off  = off - (off % bytes);
    return 32'(page + (off + longint'(k) * bytes) % 4096);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"}, 32'(o_req_ready), 32'd1);
    check({tag, "_beat_valid"}, 32'(o_beat_valid), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  task automatic check_beat(input string tag, input logic [31:0] ea, input int k, input int len);
    check({tag, "_valid"}, 32'(o_beat_valid), 32'd1);
    check({tag, "_ready_low"}, 32'(o_req_ready), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd1);
    check({tag, "_addr"}, o_beat_addr, ea);
    check({tag, "_idx"}, 32'(o_beat_idx), 32'(k));
    check({tag, "_last"}, 32'(o_beat_last), 32'(k == len));
  endtask

  // Called away from a rising edge; returns 1 ns after the edge following the last handshake.
  task automatic run_burst(input string tag, input logic [31:0] addr, input int len, input int sz,
                           input logic [1:0] bt, input int smin, input int smax);
    logic [31:0] ea;
    int          n;
    check({tag, "_accept_ready"}, 32'(o_req_ready), 32'd1);
    i_req_addr  = addr;
    i_req_len   = 8'(len);
    i_req_size  = 3'(sz);
    i_req_burst = bt;
    i_req_valid = 1'b1;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      ea = model_addr(addr, len, sz, bt, k);
      n  = $urandom_range(smax, smin);
      for (int s = 0; s < n; s++) begin
        i_beat_ready = 1'b0;
        i_req_valid  = 1'($urandom_range(1, 0));
        i_req_addr   = $urandom;
        check_beat({tag, "_stall"}, ea, k, len);
        @(posedge clk); #1;
      end
      i_req_valid  = 1'b0;
      i_beat_ready = 1'b1;
      check_beat({tag, "_beat"}, ea, k, len);
      obs[k] = o_beat_addr;
      @(posedge clk); #1;
      i_beat_ready = 1'b0;
    end
    check_idle({tag, "_done"});
  endtask

  initial begin
    logic [31:0] ra;
    int          rl, rs;
    logic [1:0]  rb;

    // Reset state, then request on the first edge after release.
    #1;
    check("rst_addr", o_beat_addr, 32'h0);
    check("rst_idx", 32'(o_beat_idx), 32'd0);
    check("rst_last", 32'(o_beat_last), 32'd0);
    check_idle("rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_burst("incr_unaligned", 32'h1002, 3, 2, 2'b01, 0, 0);
    check("incr_a0", obs[0], 32'h1002);
    check("incr_a1", obs[1], 32'h1004);
    check("incr_a2", obs[2], 32'h1008);
    check("incr_a3", obs[3], 32'h100C);

    run_burst("page", 32'h1FF8, 3, 2, 2'b01, 0, 1);
    check("page_a2", obs[2], 32'h1000);
    check("page_a3", obs[3], 32'h1004);

    run_burst("wrap", 32'h1008, 3, 2, 2'b10, 0, 1);
    check("wrap_a1", obs[1], 32'h100C);
`ifdef AXI_BURST_SEQ_WRAP_EN
    check("wrap_a2", obs[2], 32'h1000);
    check("wrap_a3", obs[3], 32'h1004);
`else
    check("wrap_a2", obs[2], 32'h1010);
    check("wrap_a3", obs[3], 32'h1014);
`endif

    run_burst("fixed", 32'h40, 2, 2, 2'b00, 3, 3);
    check("fixed_a2", obs[2], 32'h40);

    run_burst("clamp", 32'h0, 1, 3, 2'b01, 0, 0);
    check("clamp_a1", obs[1], 32'h4);

    run_burst("len0", 32'h123, 0, 0, 2'b01, 0, 2);
    run_burst("rsvd", 32'h2010, 2, 1, 2'b11, 0, 1);
    run_burst("wrap_bad_len", 32'h3008, 2, 2, 2'b10, 0, 1);

    // Reset in the middle of an 8-beat INCR burst.
    i_req_addr = 32'h5000; i_req_len = 8'd7; i_req_size = 3'd2; i_req_burst = 2'b01;
    i_req_valid = 1'b1;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    i_beat_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_idx", 32'(o_beat_idx), 32'd2);
    i_beat_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle("midrst");
    check("midrst_addr", o_beat_addr, 32'h0);
    check("midrst_idx", 32'(o_beat_idx), 32'd0);
    check("midrst_last", 32'(o_beat_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    i_beat_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("no_stale_valid", 32'(o_beat_valid), 32'd0);
    end
    i_beat_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_burst("post_rst", 32'h6004, 1, 2, 2'b01, 0, 0);

    // Randomized bursts.
    for (int t = 0; t < 40; t++) begin
      ra = $urandom;
      if ($urandom_range(3, 0) == 0) ra = (ra & 32'hFFFF_F000) | 32'hFF0 | 32'($urandom_range(15, 0));
      rb = 2'($urandom_range(3, 0));
      rs = $urandom_range(7, 0);
      if ($urandom_range(1, 0) == 1) rl = (1 << $urandom_range(4, 1)) - 1;
      else                           rl = $urandom_range(20, 0);
      run_burst("rand", ra, rl, rs, rb, 0, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
